// File: rtl/const_mon_pkg.sv
// Shared types and helpers for the tie-off rail level monitor.
package const_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MON  = 2'd2,
    ST_CLR  = 2'd3
  } mon_state_e;

  localparam int unsigned ARM_CYCLES = 2;
  localparam int unsigned POP_MAX_W  = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/const_mon_bit.sv
// One monitored tie line: 2-flop synchronizer, debounce counter, sticky flag
// and a combinational rise pulse that fires on the edge the flag sets.
module const_mon_bit
  import const_mon_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clock,
  input  logic resetb,
  input  logic tie_i,
  input  logic exp_i,
  input  logic mon_i,
  input  logic clr_i,
  output logic flag_o,
  output logic rise_o
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic       sync1_q, sync2_q;
  logic [3:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;
  logic       mismatch;

  always_comb begin
    mismatch = sync2_q ^ exp_i;
    rise_o   = mon_i && mismatch && !flag_q && (cnt_q == DEB - 4'd1);
    cnt_d    = 4'd0;
    flag_d   = flag_q;
    if (clr_i) begin
      flag_d = 1'b0;
    end else begin
      // Counter only runs while monitoring; any match or non-MON cycle zeroes it.
      if (mon_i && mismatch) cnt_d = (cnt_q == DEB) ? DEB : cnt_q + 4'd1;
      if (rise_o) flag_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= 4'd0;
      flag_q  <= 1'b0;
    end else begin
      sync1_q <= tie_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/const_level_monitor.sv
// Tie-off rail level monitor: per-line debounced sticky faults, saturating
// fault-event counter and a four-phase clear handshake for firmware.
module const_level_monitor
  import const_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock,
  input  logic             resetb,
  inout  wire              vccd,
  inout  wire              vssd,
  input  logic [WIDTH-1:0] tie_in,
  input  logic [WIDTH-1:0] tie_exp,
  input  logic             enable,
  input  logic             clear_req,
  output logic             clear_ack,
  output logic [WIDTH-1:0] fault_flag,
  output logic             fault_any,
  output logic [CNT_W-1:0] fault_cnt,
  output logic [1:0]       mon_state
);

  localparam logic [1:0]  ARM_LOAD = 2'(ARM_CYCLES);
  localparam int unsigned CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

  mon_state_e           state_q, state_d;
  logic [1:0]           timer_q, timer_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 any_q, any_d;
  logic                 ack_q;
  logic                 mon_en, clr_en;
  logic [WIDTH-1:0]     rise;
  logic [POP_MAX_W-1:0] rise_ext;
  int unsigned          sum;
  logic                 unused_pwr;

  assign unused_pwr = vccd ^ vssd;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLR;
        end else if (enable) begin
          state_d = ST_ARM;
          timer_d = ARM_LOAD;
        end
      end
      ST_ARM: begin
        // clear_req is deliberately ignored here; it is picked up in MON.
        if (!enable) begin
          state_d = ST_IDLE;
          timer_d = 2'd0;
        end else if (timer_q <= 2'd1) begin
          state_d = ST_MON;
          timer_d = 2'd0;
        end else begin
          timer_d = timer_q - 2'd1;
        end
      end
      ST_MON: begin
        if (clear_req)   state_d = ST_CLR;
        else if (!enable) state_d = ST_IDLE;
      end
      ST_CLR: begin
        if (!clear_req) begin
          if (enable) begin
            state_d = ST_ARM;
            timer_d = ARM_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear handshake: ack mirrors "state is CLR", so it rises one edge after
  // clear_req is seen high and falls one edge after it is seen low.
  assign mon_en = (state_q == ST_MON) && (state_d == ST_MON);
  assign clr_en = (state_d == ST_CLR);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    const_mon_bit #(.DEBOUNCE(DEBOUNCE)) u_bit (
      .clock  (clock),
      .resetb (resetb),
      .tie_i  (tie_in[i]),
      .exp_i  (tie_exp[i]),
      .mon_i  (mon_en),
      .clr_i  (clr_en),
      .flag_o (fault_flag[i]),
      .rise_o (rise[i])
    );
  end

  assign rise_ext = POP_MAX_W'(rise);

  always_comb begin
    sum   = 32'(cnt_q) + popcount(rise_ext);
    cnt_d = (sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(sum);
    any_d = |(fault_flag | rise);
    if (clr_en) begin
      cnt_d = '0;
      any_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      timer_q <= 2'd0;
      cnt_q   <= '0;
      any_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      any_q   <= any_d;
      ack_q   <= clr_en;
    end
  end

  assign mon_state = state_q;
  assign clear_ack = ack_q;
  assign fault_any = any_q;
  assign fault_cnt = cnt_q;

endmodule

// File: tb/tb_const_level_monitor.sv
// Bench for const_level_monitor: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the monitoring rules.
module tb_const_level_monitor;

  localparam int DEB = 4;

  logic       clock;
  logic       resetb;
  wire        vccd;
  wire        vssd;
  logic [7:0] tie_in, tie_exp;
  logic       enable, clear_req;
  logic       clear_ack, fault_any;
  logic [7:0] fault_flag, fault_cnt;
  logic [1:0] mon_state;
  logic       clear_ack_s, fault_any_s;
  logic [7:0] fault_flag_s;
  logic [1:0] fault_cnt_s, mon_state_s;

  int total = 0;
  int bad   = 0;

  assign vccd = 1'b1;
  assign vssd = 1'b0;

  const_level_monitor #(.WIDTH(8), .DEBOUNCE(DEB), .CNT_W(8)) dut (
    .clock(clock), .resetb(resetb), .vccd(vccd), .vssd(vssd),
    .tie_in(tie_in), .tie_exp(tie_exp), .enable(enable), .clear_req(clear_req),
    .clear_ack(clear_ack), .fault_flag(fault_flag), .fault_any(fault_any),
    .fault_cnt(fault_cnt), .mon_state(mon_state)
  );

  const_level_monitor #(.WIDTH(8), .DEBOUNCE(DEB), .CNT_W(2)) dut_sat (
    .clock(clock), .resetb(resetb), .vccd(vccd), .vssd(vssd),
    .tie_in(tie_in), .tie_exp(tie_exp), .enable(enable), .clear_req(clear_req),
    .clear_ack(clear_ack_s), .fault_flag(fault_flag_s), .fault_any(fault_any_s),
    .fault_cnt(fault_cnt_s), .mon_state(mon_state_s)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: state as plain ints, sync delay as two sample copies,
  // per-line mismatch run lengths, event counts clamped with min().
  int         m_state;
  int         m_arm_left;
  logic [7:0] m_s1, m_s2, m_flag;
  int         m_run[8];
  int         m_cnt, m_cnt_sat;
  logic       m_ack;

  always @(posedge clock) begin : model
    int         nxt;
    logic [7:0] newf;
    if (!resetb) begin
      m_state = 0; m_arm_left = 0; m_s1 = 0; m_s2 = 0; m_flag = 0;
      m_cnt = 0; m_cnt_sat = 0; m_ack = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      newf = 8'd0;
      nxt  = m_state;
      case (m_state)
        0: if (clear_req) nxt = 3;
           else if (enable) begin nxt = 1; m_arm_left = 2; end
        1: if (!enable) nxt = 0;
           else begin
             m_arm_left = m_arm_left - 1;
             if (m_arm_left == 0) nxt = 2;
           end
        2: if (clear_req) nxt = 3;
           else if (!enable) nxt = 0;
           else begin
             for (int i = 0; i < 8; i++) begin
               if (m_s2[i] !== tie_exp[i]) begin
                 if (m_run[i] < DEB) begin
                   m_run[i] = m_run[i] + 1;
                   if (m_run[i] == DEB && !m_flag[i]) newf[i] = 1'b1;
                 end
               end else begin
                 m_run[i] = 0;
               end
             end
           end
        default: if (!clear_req) nxt = enable ? 1 : 0;
      endcase
      if (m_state == 3 && nxt == 1) m_arm_left = 2;
      if (nxt == 3) begin
        m_flag = 0; m_cnt = 0; m_cnt_sat = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
      end else begin
        if (nxt != 2) for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_flag    = m_flag | newf;
        m_cnt     = (m_cnt + $countones(newf) > 255) ? 255 : m_cnt + $countones(newf);
        m_cnt_sat = (m_cnt_sat + $countones(newf) > 3) ? 3 : m_cnt_sat + $countones(newf);
      end
      m_ack   = (nxt == 3);
      m_state = nxt;
      m_s2    = m_s1;
      m_s1    = tie_in;
    end
  end

  // Driver
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetb = 1'b0; enable = 1'b0; clear_req = 1'b0;
    tie_exp = 8'hA5; tie_in = 8'hA5;
    tick(); tick();
    total++; if (mon_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", mon_state); end
    total++; if (fault_flag !== 8'h00) begin bad++; $display("FAIL reset_flag: got %h want 00", fault_flag); end
    total++; if (fault_any !== 1'b0) begin bad++; $display("FAIL reset_any: got %b want 0", fault_any); end
    total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", fault_cnt); end
    total++; if (clear_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", clear_ack); end
    total++; if (fault_cnt_s !== 2'd0) begin bad++; $display("FAIL reset_cnt_sat: got %0d want 0", fault_cnt_s); end
    resetb = 1'b1;
    tick();
  endtask

  task automatic test_clean_run();
    enable = 1'b1;
    tick();
    total++; if (mon_state !== 2'd1) begin bad++; $display("FAIL clean_arm1: got %0d want 1", mon_state); end
    tick();
    total++; if (mon_state !== 2'd1) begin bad++; $display("FAIL clean_arm2: got %0d want 1", mon_state); end
    tick();
    total++; if (mon_state !== 2'd2) begin bad++; $display("FAIL clean_mon: got %0d want 2", mon_state); end
    repeat (97) tick();
    total++; if (fault_flag !== 8'h00) begin bad++; $display("FAIL clean_flag: got %h want 00", fault_flag); end
    total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL clean_cnt: got %0d want 0", fault_cnt); end
    total++; if (mon_state !== 2'd2) begin bad++; $display("FAIL clean_state_end: got %0d want 2", mon_state); end
  endtask

  task automatic test_debounced_fault();
    tie_in = 8'hA5 ^ 8'h08;
    repeat (5) tick();
    total++; if (fault_flag !== 8'h00) begin bad++; $display("FAIL deb_early: got %h want 00", fault_flag); end
    tick();
    total++; if (fault_flag !== 8'h08) begin bad++; $display("FAIL deb_flag: got %h want 08", fault_flag); end
    total++; if (fault_cnt !== 8'd1) begin bad++; $display("FAIL deb_cnt: got %0d want 1", fault_cnt); end
    total++; if (fault_any !== 1'b1) begin bad++; $display("FAIL deb_any: got %b want 1", fault_any); end
    tie_in = 8'hA5;
    repeat (8) tick();
    total++; if (fault_flag !== 8'h08) begin bad++; $display("FAIL deb_sticky: got %h want 08", fault_flag); end
    total++; if (fault_cnt !== 8'd1) begin bad++; $display("FAIL deb_sticky_cnt: got %0d want 1", fault_cnt); end
  endtask

  task automatic test_glitch_reject();
    tie_in = 8'hA5 ^ 8'h01;
    repeat (3) tick();
    tie_in = 8'hA5;
    repeat (8) tick();
    total++; if (fault_flag !== 8'h08) begin bad++; $display("FAIL glitch3_flag: got %h want 08", fault_flag); end
    total++; if (fault_cnt !== 8'd1) begin bad++; $display("FAIL glitch3_cnt: got %0d want 1", fault_cnt); end
    // A pulse exactly DEBOUNCE samples long is the shortest that must flag.
    tie_in = 8'hA5 ^ 8'h02;
    repeat (4) tick();
    tie_in = 8'hA5;
    repeat (4) tick();
    total++; if (fault_flag !== 8'h0A) begin bad++; $display("FAIL glitch4_flag: got %h want 0a", fault_flag); end
    total++; if (fault_cnt !== 8'd2) begin bad++; $display("FAIL glitch4_cnt: got %0d want 2", fault_cnt); end
  endtask

  task automatic test_clear_handshake();
    tie_in = 8'hA5 ^ 8'h08;
    clear_req = 1'b1;
    tick();
    total++; if (clear_ack !== 1'b1) begin bad++; $display("FAIL clr_ack_rise: got %b want 1", clear_ack); end
    total++; if (mon_state !== 2'd3) begin bad++; $display("FAIL clr_state: got %0d want 3", mon_state); end
    total++; if (fault_flag !== 8'h00) begin bad++; $display("FAIL clr_flag: got %h want 00", fault_flag); end
    total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", fault_cnt); end
    total++; if (fault_any !== 1'b0) begin bad++; $display("FAIL clr_any: got %b want 0", fault_any); end
    repeat (6) tick();
    total++; if (fault_flag !== 8'h00) begin bad++; $display("FAIL clr_held_flag: got %h want 00", fault_flag); end
    total++; if (clear_ack !== 1'b1) begin bad++; $display("FAIL clr_ack_held: got %b want 1", clear_ack); end
    clear_req = 1'b0;
    tick();
    total++; if (clear_ack !== 1'b0) begin bad++; $display("FAIL clr_ack_fall: got %b want 0", clear_ack); end
    total++; if (mon_state !== 2'd1) begin bad++; $display("FAIL clr_rearm1: got %0d want 1", mon_state); end
    tick();
    total++; if (mon_state !== 2'd1) begin bad++; $display("FAIL clr_rearm2: got %0d want 1", mon_state); end
    tick();
    total++; if (mon_state !== 2'd2) begin bad++; $display("FAIL clr_remon: got %0d want 2", mon_state); end
    repeat (3) tick();
    total++; if (fault_flag !== 8'h00) begin bad++; $display("FAIL clr_reflag_early: got %h want 00", fault_flag); end
    tick();
    total++; if (fault_flag !== 8'h08) begin bad++; $display("FAIL clr_reflag: got %h want 08", fault_flag); end
    total++; if (fault_cnt !== 8'd1) begin bad++; $display("FAIL clr_reflag_cnt: got %0d want 1", fault_cnt); end
  endtask

  task automatic test_multi_bit_saturation();
    tie_in = 8'hA5;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (3) tick();
    total++; if (mon_state !== 2'd2) begin bad++; $display("FAIL multi_mon: got %0d want 2", mon_state); end
    tie_in = 8'hA5 ^ 8'h07;
    repeat (5) tick();
    total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL multi_cnt_early: got %0d want 0", fault_cnt); end
    tick();
    total++; if (fault_cnt !== 8'd3) begin bad++; $display("FAIL multi_cnt: got %0d want 3", fault_cnt); end
    total++; if (fault_flag !== 8'h07) begin bad++; $display("FAIL multi_flag: got %h want 07", fault_flag); end
    total++; if (fault_cnt_s !== 2'd3) begin bad++; $display("FAIL multi_cnt_sat: got %0d want 3", fault_cnt_s); end
    tie_in = 8'hA5 ^ 8'h37;
    repeat (6) tick();
    total++; if (fault_cnt !== 8'd5) begin bad++; $display("FAIL sat_cnt5: got %0d want 5", fault_cnt); end
    total++; if (fault_cnt_s !== 2'd3) begin bad++; $display("FAIL sat_hold1: got %0d want 3", fault_cnt_s); end
    total++; if (fault_flag_s !== 8'h37) begin bad++; $display("FAIL sat_flag: got %h want 37", fault_flag_s); end
    tie_in = 8'hA5 ^ 8'hB7;
    repeat (6) tick();
    total++; if (fault_cnt !== 8'd6) begin bad++; $display("FAIL sat_cnt6: got %0d want 6", fault_cnt); end
    total++; if (fault_cnt_s !== 2'd3) begin bad++; $display("FAIL sat_hold2: got %0d want 3", fault_cnt_s); end
  endtask

  task automatic test_reset_mid_debounce();
    tie_in = 8'hA5 ^ 8'hF7;
    repeat (5) tick();
    total++; if (fault_flag !== 8'hB7) begin bad++; $display("FAIL midrst_preflag: got %h want b7", fault_flag); end
    resetb = 1'b0;
    tick();
    total++; if (mon_state !== 2'd0) begin bad++; $display("FAIL midrst_state: got %0d want 0", mon_state); end
    total++; if (fault_flag !== 8'h00) begin bad++; $display("FAIL midrst_flag: got %h want 00", fault_flag); end
    total++; if (fault_cnt !== 8'd0) begin bad++; $display("FAIL midrst_cnt: got %0d want 0", fault_cnt); end
    total++; if (fault_any !== 1'b0) begin bad++; $display("FAIL midrst_any: got %b want 0", fault_any); end
    total++; if (clear_ack !== 1'b0) begin bad++; $display("FAIL midrst_ack: got %b want 0", clear_ack); end
    resetb = 1'b1;
    tie_in = 8'hA5;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] pat;
    pat = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) pat = pat ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) tie_exp = 8'($urandom);
      if ($urandom_range(0, 39) == 0) clear_req = ~clear_req;
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      resetb = ($urandom_range(0, 499) != 0);
      tie_in = tie_exp ^ pat;
      tick();
      total++; if (mon_state !== 2'(m_state)) begin bad++; $display("FAIL rnd_state c=%0d: got %0d want %0d", c, mon_state, m_state); end
      total++; if (fault_flag !== m_flag) begin bad++; $display("FAIL rnd_flag c=%0d: got %h want %h", c, fault_flag, m_flag); end
      total++; if (fault_any !== (|m_flag)) begin bad++; $display("FAIL rnd_any c=%0d: got %b want %b", c, fault_any, |m_flag); end
      total++; if (fault_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, fault_cnt, m_cnt); end
      total++; if (clear_ack !== m_ack) begin bad++; $display("FAIL rnd_ack c=%0d: got %b want %b", c, clear_ack, m_ack); end
      total++; if (fault_cnt_s !== 2'(m_cnt_sat)) begin bad++; $display("FAIL rnd_cnt_sat c=%0d: got %0d want %0d", c, fault_cnt_s, m_cnt_sat); end
      total++; if ({mon_state_s, clear_ack_s, fault_any_s, fault_flag_s} !== {2'(m_state), m_ack, |m_flag, m_flag})
        begin bad++; $display("FAIL rnd_sat_misc c=%0d: got %b%b%b%h want %0d%b%b%h", c, mon_state_s, clear_ack_s, fault_any_s, fault_flag_s, m_state, m_ack, |m_flag, m_flag); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_debounced_fault();
    test_glitch_reject();
    test_clear_handshake();
    test_multi_bit_saturation();
    test_reset_mid_debounce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/const_level_monitor.md
# const_level_monitor

Monitors the buffered 1.8 V tie-off rails (`one`/`zero` and other static tie lines) where the I/O cells and user logic consume them. It raises sticky per-line fault flags when a received level stays different from its expected constant for a debounced number of clocks. It counts fault events and exposes a four-phase clear handshake for housekeeping firmware. It sits on the receiving end of the tie-off distribution, clocked by the core clock.

## Interface
- `WIDTH`, 8: number of monitored tie lines.
- `DEBOUNCE`, 4: consecutive mismatching synchronized samples required to declare a fault; legal range 1..15.
- `CNT_W`, 8: width of the saturating fault-event counter.

- `clock`  in  1  core clock; all logic on the rising edge.
- `resetb`  in  1  reset, synchronous and active-low.
- `vccd`  inout  1  1.8 V supply; pass-through only.
- `vssd`  inout  1  1.8 V ground; pass-through only.
- `tie_in`  in  WIDTH  monitored tie lines, treated as asynchronous.
- `tie_exp`  in  WIDTH  expected constant per line; quasi-static, sampled directly.
- `enable`  in  1  monitoring enable, level.
- `clear_req`  in  1  clear request, four-phase level.
- `clear_ack`  out  1  clear acknowledge.
- `fault_flag`  out  WIDTH  sticky per-line fault.
- `fault_any`  out  1  OR of `fault_flag`, registered.
- `fault_cnt`  out  CNT_W  saturating count of fault events.
- `mon_state`  out  2  current FSM state encoding.

## Operation
- **States:**
  - IDLE=0: monitoring off.
  - ARM=1: synchronizer fill.
  - MON=2: active.
  - CLR=3: clear in progress.
- **Reset (`resetb`=0 at an edge):**
  - state→IDLE.
  - All outputs 0.
  - Synchronizer flops, debounce counters and ARM timer all 0.
- **IDLE:**
  - `enable`=1 → ARM, with ARM timer loaded to 2.
  - `clear_req`=1 in IDLE → CLR.
- **ARM:**
  - Decrement the timer each cycle; at 0 → MON.
  - No mismatch counting in ARM.
  - `enable`=0 → IDLE.
- **MON:**
  - Per line, a mismatch is `sync2[i] != tie_exp[i]`.
  - On a mismatch, the debounce counter increments, saturating at DEBOUNCE.
  - A match clears the counter to 0.
  - `fault_flag[i]` sets on the edge where the counter goes DEBOUNCE-1→DEBOUNCE. It then stays set until CLR or reset.
  - An already-set flag does not re-trigger.
  - `fault_cnt` += popcount of the flags newly set this cycle, saturating at 2^CNT_W-1.
  - `clear_req`=1 → CLR. This has priority over `enable`=0.
  - `enable`=0 → IDLE. Debounce counters are zeroed; flags and count are retained.
- **CLR:**
  - On entry edge: zero `fault_flag`, `fault_cnt` and debounce counters.
  - `clear_ack`=1 for as long as the state is CLR.
  - Fault detection is suspended; mismatches during CLR are ignored.
  - `clear_req`=0 → ARM if `enable`=1, else IDLE. `clear_ack` drops on that same edge.
- **Simultaneous events:**
  - A fault rising on the same edge that CLR is entered is discarded; clear wins.
  - A fault on a line already flagged adds nothing to the count.

## Timing
- Two-flop synchronizer per line (`sync1`, `sync2`), always clocking, including in IDLE.
- **Fault latency:** counting the edge that first samples the mismatch into `sync1` as edge 1, `fault_flag` is high after edge DEBOUNCE+2. With DEBOUNCE=4, that is after edge 6.
- `fault_any` and `fault_cnt` update on the same edge as the flag.
- A glitch shorter than DEBOUNCE synchronized cycles never sets a flag.
- **Clear handshake:**
  - `clear_ack` rises 1 edge after `clear_req` is sampled high in IDLE or MON.
  - `clear_ack` falls 1 edge after `clear_req` is sampled low.
  - `clear_req` raised during ARM is honoured at the first MON cycle.
- **Re-arm:** after CLR or IDLE, detection resumes after a 2-cycle ARM window.
- **Reset mid-operation:** reset overrides all states in one edge; no flag or count survives.

## Structure
- Package `const_mon_pkg` holds:
  - the state enum (IDLE, ARM, MON, CLR);
  - `ARM_CYCLES`=2;
  - a `popcount` function.
- Sub-module `const_mon_bit`, instantiated WIDTH times, contains:
  - the 2-flop synchronizer;
  - the debounce counter;
  - the sticky flag;
  - a one-cycle `fault_rise` pulse.
- The top level holds the FSM, the popcount/saturating counter, `fault_any` and the handshake.

## Test plan
- **Clean run:** `tie_in`=`tie_exp`=8'hA5, `enable`=1 for 100 cycles → `fault_flag`=0, `fault_cnt`=0, `mon_state`=2 from the 3rd cycle after enable.
- **Debounced fault:** in MON, flip `tie_in[3]` and hold it → `fault_flag`=8'h08 after edge 6, `fault_cnt`=1, `fault_any`=1. Restoring the line leaves the flag set.
- **Glitch reject:** flip `tie_in[0]` for 3 cycles with DEBOUNCE=4 → no flag, counter returns to 0.
- **Multi-bit and saturation:**
  - Flip bits 0, 1 and 2 together → `fault_cnt`=3 on one edge.
  - With CNT_W=2 and repeated clear-free faults on separate lines → `fault_cnt` holds at 3.
- **Clear handshake:**
  - Raise `clear_req` with flags set → `clear_ack` 1 edge later, flags/count = 0.
  - Mismatch held during CLR → no flag.
  - Drop `clear_req` → `clear_ack` falls, ARM for 2 cycles, then MON re-flags the held mismatch after DEBOUNCE cycles.
- **Reset mid-debounce:** assert `resetb`=0 at debounce count 3 → all outputs 0 next edge, state IDLE.
